// File: rtl/soc_ctrl_pll_seq.sv
// soc_ctrl_pll_seq: per-domain PLL reprogramming sequencer.
// Runs gate -> reset -> apply dividers -> wait lock (with timeout) ->
// settle -> release for every accepted divider change. After global reset
// it performs the same bring-up with the default dividers.
// Optional lock-loss monitor: define SOC_CTRL_PLL_SEQ_LOCK_MON_EN.
module soc_ctrl_pll_seq #(
    parameter int REF_DIV_BW    = 4,
    parameter int FB_DIV_BW     = 12,
    parameter int DEF_REF_DIV   = 1,
    parameter int DEF_FB_DIV    = 8,
    parameter int GATE_CYCLES   = 4,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int RST_HOLD      = 8
) (
    input  logic                  ref_clk_i,
    input  logic                  glb_arst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [REF_DIV_BW-1:0] req_ref_div_i,
    input  logic [FB_DIV_BW-1:0]  req_fb_div_i,
    output logic [REF_DIV_BW-1:0] pll_ref_div_o,
    output logic [FB_DIV_BW-1:0]  pll_fb_div_o,
    input  logic                  pll_locked_i,
    output logic                  clk_en_o,
    output logic                  arst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic                  bad_req_o,
    output logic                  lock_lost_o
);
    localparam int MAX_GS = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int MAX_LR = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
    localparam int MAX_P  = (MAX_GS > MAX_LR) ? MAX_GS : MAX_LR;
    localparam int CNT_BW = $clog2(MAX_P) + 1;

    localparam logic [CNT_BW-1:0] GATE_LAST   = CNT_BW'(GATE_CYCLES - 1);
    localparam logic [CNT_BW-1:0] TO_LAST     = CNT_BW'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_BW-1:0] SETTLE_LAST = CNT_BW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_BW-1:0] HOLD_LAST   = CNT_BW'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE, GATE, RESET, APPLY, WAIT_LOCK, SETTLE, RELEASE, ERROR
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_BW-1:0]       cnt_reg, cnt_next, cnt_inc;
    logic                    lock_meta_reg, lock_s_reg;
    logic [REF_DIV_BW-1:0]   req_ref_reg, req_ref_next, pll_ref_reg, pll_ref_next;
    logic [FB_DIV_BW-1:0]    req_fb_reg, req_fb_next, pll_fb_reg, pll_fb_next;
    logic                    done_reg, done_next;
    logic                    bad_reg, bad_next;
    logic                    timeout_reg, timeout_next;
`ifdef SOC_CTRL_PLL_SEQ_LOCK_MON_EN
    logic                    lost_reg, lost_next;
    logic                    low_seen_reg, low_seen_next;
`endif

    // Counters saturate instead of wrapping.
    assign cnt_inc = (cnt_reg == {CNT_BW{1'b1}}) ? cnt_reg : cnt_reg + CNT_BW'(1);

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
        if (!glb_arst_ni) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= pll_locked_i;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    // State, counter, divider and flag registers; reset starts bring-up.
    always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
        if (!glb_arst_ni) begin
            state_reg   <= WAIT_LOCK;
            cnt_reg     <= '0;
            req_ref_reg <= REF_DIV_BW'(DEF_REF_DIV);
            req_fb_reg  <= FB_DIV_BW'(DEF_FB_DIV);
            pll_ref_reg <= REF_DIV_BW'(DEF_REF_DIV);
            pll_fb_reg  <= FB_DIV_BW'(DEF_FB_DIV);
            done_reg    <= 1'b0;
            bad_reg     <= 1'b0;
            timeout_reg <= 1'b0;
`ifdef SOC_CTRL_PLL_SEQ_LOCK_MON_EN
            lost_reg     <= 1'b0;
            low_seen_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            req_ref_reg <= req_ref_next;
            req_fb_reg  <= req_fb_next;
            pll_ref_reg <= pll_ref_next;
            pll_fb_reg  <= pll_fb_next;
            done_reg    <= done_next;
            bad_reg     <= bad_next;
            timeout_reg <= timeout_next;
`ifdef SOC_CTRL_PLL_SEQ_LOCK_MON_EN
            lost_reg     <= lost_next;
            low_seen_reg <= low_seen_next;
`endif
        end
    end

    // Next-state logic: sequence progression, request handling, flags.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        req_ref_next = req_ref_reg;
        req_fb_next  = req_fb_reg;
        pll_ref_next = pll_ref_reg;
        pll_fb_next  = pll_fb_reg;
        done_next    = 1'b0;
        bad_next     = 1'b0;
        timeout_next = timeout_reg;
`ifdef SOC_CTRL_PLL_SEQ_LOCK_MON_EN
        lost_next     = lost_reg;
        low_seen_next = 1'b0;
`endif
        case (state_reg)
            IDLE, ERROR: begin
                if (req_valid_i) begin
                    if (req_ref_div_i == '0 || req_fb_div_i == '0) begin
                        bad_next = 1'b1;
                    end else begin
                        req_ref_next = req_ref_div_i;
                        req_fb_next  = req_fb_div_i;
                        timeout_next = 1'b0;
`ifdef SOC_CTRL_PLL_SEQ_LOCK_MON_EN
                        lost_next    = 1'b0;
`endif
                        cnt_next     = '0;
                        state_next   = GATE;
                    end
                end
`ifdef SOC_CTRL_PLL_SEQ_LOCK_MON_EN
                // Two consecutive low lock samples in IDLE rerun the sequence
                // with the dividers currently in use.
                else if (state_reg == IDLE && !lock_s_reg) begin
                    if (low_seen_reg) begin
                        lost_next  = 1'b1;
                        cnt_next   = '0;
                        state_next = GATE;
                    end else begin
                        low_seen_next = 1'b1;
                    end
                end
`endif
            end
            GATE: begin
                if (cnt_reg == GATE_LAST) begin
                    cnt_next   = '0;
                    state_next = RESET;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            RESET: begin
                // Load the dividers so they are visible in the first APPLY cycle.
                pll_ref_next = req_ref_reg;
                pll_fb_next  = req_fb_reg;
                state_next   = APPLY;
            end
            APPLY: begin
                cnt_next   = '0;
                state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s_reg) begin
                    cnt_next   = '0;
                    state_next = SETTLE;
                end else if (cnt_reg == TO_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = ERROR;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            SETTLE: begin
                if (!lock_s_reg) begin
                    cnt_next   = '0;
                    state_next = WAIT_LOCK;
                end else if (cnt_reg == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = RELEASE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            RELEASE: begin
                if (cnt_reg == HOLD_LAST) begin
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Domain controls decoded from state. GATE keeps reset released so a
    // running domain only loses its clock before reset asserts.
    always_comb begin
        clk_en_o    = (state_reg == IDLE) || (state_reg == RELEASE);
        arst_n_o    = (state_reg == IDLE) || (state_reg == GATE);
        busy_o      = !((state_reg == IDLE) || (state_reg == ERROR));
        req_ready_o = (state_reg == IDLE) || (state_reg == ERROR);
    end

    assign pll_ref_div_o = pll_ref_reg;
    assign pll_fb_div_o  = pll_fb_reg;
    assign done_o        = done_reg;
    assign bad_req_o     = bad_reg;
    assign timeout_o     = timeout_reg;
`ifdef SOC_CTRL_PLL_SEQ_LOCK_MON_EN
    assign lock_lost_o   = lost_reg;
`else
    assign lock_lost_o   = 1'b0;
`endif

endmodule

// File: tb/tb_soc_ctrl_pll_seq.sv
// tb_soc_ctrl_pll_seq: self-checking bench for soc_ctrl_pll_seq.
// Table of directed sequences, randomized sequences against a timeline
// model, and hand-written reset / lock-monitor sequences.
module tb_soc_ctrl_pll_seq;
    localparam int G = 4;
    localparam int T = 64;
    localparam int S = 16;
    localparam int H = 8;

    logic        ref_clk_i = 1'b0;
    logic        glb_arst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_ref_div_i = '0;
    logic [11:0] req_fb_div_i = '0;
    logic [3:0]  pll_ref_div_o;
    logic [11:0] pll_fb_div_o;
    logic        pll_locked_i = 1'b0;
    logic        clk_en_o, arst_n_o, busy_o, done_o, timeout_o, bad_req_o, lock_lost_o;

    soc_ctrl_pll_seq #(
        .REF_DIV_BW(4), .FB_DIV_BW(12), .DEF_REF_DIV(1), .DEF_FB_DIV(8),
        .GATE_CYCLES(G), .LOCK_TIMEOUT(T), .SETTLE_CYCLES(S), .RST_HOLD(H)
    ) dut (
        .ref_clk_i(ref_clk_i), .glb_arst_ni(glb_arst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_ref_div_i(req_ref_div_i), .req_fb_div_i(req_fb_div_i),
        .pll_ref_div_o(pll_ref_div_o), .pll_fb_div_o(pll_fb_div_o),
        .pll_locked_i(pll_locked_i), .clk_en_o(clk_en_o), .arst_n_o(arst_n_o),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .bad_req_o(bad_req_o), .lock_lost_o(lock_lost_o)
    );

    always #5 ref_clk_i = ~ref_clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0]  cur_ref = 4'd1;
    logic [11:0] cur_fb  = 12'd8;
    bit in_err = 1'b0;

    // Lock waveform, in cycles after the accepting edge.
    int lon  = 0;
    int gat  = -100;
    int glen = 0;
    bit pre  = 1'b1;

    typedef struct {
        logic [3:0]  rdiv;
        logic [11:0] fdiv;
        int          lon;
        int          gat;
        int          glen;
        bit          hold;
        int          bad;
        int          exp_evt;
        bit          exp_to;
    } vec_t;
    vec_t tbl[9];

    function automatic bit raw_at(int k);
        if (k < 0) return pre;
        return (k >= lon) && !((k >= gat) && (k < gat + glen));
    endfunction

    // Synchronized lock lags the raw lock by two cycles.
    function automatic bit ls_at(int k);
        return raw_at(k - 2);
    endfunction

    // Timeline model: lock wait from w0, settle needs S consecutive lock
    // samples, release lasts H cycles; returns release start and final cycle.
    task automatic model(input int w0, output int rel, output int fin, output bit to);
        int w, c, b;
        w = w0; rel = 0; fin = 0; to = 1'b0;
        for (int guard = 0; guard < 64; guard++) begin
            c = w;
            while (c < w + T && !ls_at(c)) c++;
            if (c == w + T) begin
                to = 1'b1; fin = w + T; rel = fin;
                return;
            end
            b = -1;
            for (int j = c + 1; j <= c + S; j++)
                if (!ls_at(j) && b < 0) b = j;
            if (b < 0) begin
                rel = c + S + 1; fin = rel + H;
                return;
            end
            w = b + 1;
        end
    endtask

    function automatic logic [23:0] outs();
        return {clk_en_o, arst_n_o, busy_o, req_ready_o, done_o, timeout_o,
                bad_req_o, lock_lost_o, pll_ref_div_o, pll_fb_div_o};
    endfunction

    function automatic logic [23:0] expv(int k, bit gate, int rel, int fin, bit to,
                                         logic [3:0] oref, logic [3:0] nref,
                                         logic [11:0] ofb, logic [11:0] nfb, bit lost);
        logic [7:0] f;
        if (to && k >= fin)
            f = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, lost};
        else if (!to && k >= fin)
            f = {1'b1, 1'b1, 1'b0, 1'b1, (k == fin), 1'b0, 1'b0, lost};
        else if (gate && k < G)
            f = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lost};
        else if (!to && k >= rel)
            f = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lost};
        else
            f = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lost};
        if (gate && k < G + 1) return {f, oref, ofb};
        return {f, nref, nfb};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after the edge that starts the sequence (cycle 0).
    task automatic check_seq(input bit gate, input logic [3:0] nref, input logic [11:0] nfb,
                             input bit lost, input string tag, output int evt, output bit to);
        int rel, fin;
        model(gate ? G + 2 : 0, rel, fin, to);
        evt = -1;
        for (int k = 0; k <= fin; k++) begin
            if (k > 0) begin
                @(posedge ref_clk_i); #1;
            end
            pll_locked_i = raw_at(k);
            @(negedge ref_clk_i);
            if (evt < 0 && (to ? timeout_o : done_o)) evt = k;
            check($sformatf("%s k=%0d", tag, k), outs(),
                  expv(k, gate, rel, fin, to, cur_ref, nref, cur_fb, nfb, lost));
        end
        cur_ref = nref;
        cur_fb  = nfb;
        in_err  = to;
        pll_locked_i = 1'b1;
        $display("[TB] seq %s ref=%0d fb=%0d timeout=%0d event_cycle=%0d", tag, nref, nfb, to, evt);
    endtask

    // Called at a negedge; presents a request and checks the whole sequence.
    task automatic run_seq(input logic [3:0] r, input logic [11:0] f, input bit hold,
                           input string tag, output int evt, output bit to);
        int n;
        req_ref_div_i = r;
        req_fb_div_i  = f;
        req_valid_i   = 1'b1;
        n = 0;
        while (!req_ready_o && n < 300) begin
            @(negedge ref_clk_i); n++;
        end
        if (!req_ready_o) begin
            n_tests++; n_fail++;
            $display("FAIL %s accept_wait: ready=0 required 1", tag);
            req_valid_i = 1'b0; evt = -1; to = 1'b0;
            return;
        end
        @(posedge ref_clk_i); #1;
        if (!hold) req_valid_i = 1'b0;
        check_seq(1'b1, r, f, 1'b0, tag, evt, to);
    endtask

    // Called at a negedge in IDLE or ERROR; request with a zero divider.
    task automatic run_bad(input logic [3:0] r, input logic [11:0] f, input string tag);
        logic [23:0] base;
        base = in_err ? {8'b0001_0100, cur_ref, cur_fb} : {8'b1101_0000, cur_ref, cur_fb};
        req_ref_div_i = r;
        req_fb_div_i  = f;
        req_valid_i   = 1'b1;
        @(posedge ref_clk_i); #1;
        req_valid_i = 1'b0;
        @(negedge ref_clk_i);
        check({tag, " pulse"}, outs(), base | 24'h02_0000);
        @(negedge ref_clk_i);
        check({tag, " after"}, outs(), base);
        $display("[TB] bad %s ref=%0d fb=%0d", tag, r, f);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int evt;
        bit to;
        logic [3:0]  rr;
        logic [11:0] ff;

        tbl[0] = '{4'd2,  12'd25,   10, -100, 0, 1'b0, 1, 37, 1'b0};
        tbl[1] = '{4'd5,  12'd100,   0, -100, 0, 1'b0, 0, 31, 1'b0};
        tbl[2] = '{4'd3,  12'd30,   10,   21, 1, 1'b0, 0, 49, 1'b0};
        tbl[3] = '{4'd4,  12'd40,   67, -100, 0, 1'b0, 0, 94, 1'b0};
        tbl[4] = '{4'd4,  12'd41,   68, -100, 0, 1'b0, 2, 70, 1'b1};
        tbl[5] = '{4'd1,  12'd10,    5, -100, 0, 1'b0, 0, 32, 1'b0};
        tbl[6] = '{4'd15, 12'd4095,  3, -100, 0, 1'b0, 0, 31, 1'b0};
        tbl[7] = '{4'd7,  12'd77,   10, -100, 0, 1'b1, 0, 37, 1'b0};
        tbl[8] = '{4'd7,  12'd77,   10, -100, 0, 1'b0, 0, 37, 1'b0};

        // Reset values, then power-on bring-up with lock at cycle 20.
        #23;
        check("reset", outs(), {8'b0010_0000, 4'd1, 12'd8});
        @(posedge ref_clk_i); #1;
        glb_arst_ni = 1'b1;
        lon = 20; gat = -100; glen = 0; pre = 1'b0;
        check_seq(1'b0, 4'd1, 12'd8, 1'b0, "poweron", evt, to);
        check_int("poweron done_cycle", evt, 47);

        // Directed table.
        pre = 1'b1;
        for (int i = 0; i < 9; i++) begin
            lon = tbl[i].lon; gat = tbl[i].gat; glen = tbl[i].glen;
            run_seq(tbl[i].rdiv, tbl[i].fdiv, tbl[i].hold, $sformatf("tbl%0d", i), evt, to);
            check_int($sformatf("tbl%0d event_cycle", i), evt, tbl[i].exp_evt);
            check_int($sformatf("tbl%0d timeout", i), int'(to), int'(tbl[i].exp_to));
            if (tbl[i].bad == 1) run_bad(tbl[i].rdiv, 12'd0, $sformatf("tbl%0d fb0", i));
            if (tbl[i].bad == 2) run_bad(4'd0, tbl[i].fdiv, $sformatf("tbl%0d ref0", i));
        end

        // Randomized sequences checked against the timeline model.
        for (int r = 0; r < 12; r++) begin
            rr  = 4'($urandom_range(1, 15));
            ff  = 12'($urandom_range(1, 4095));
            lon = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 1) begin
                gat  = lon + 2 + int'($urandom_range(0, 20));
                glen = int'($urandom_range(1, 3));
            end else begin
                gat = -100; glen = 0;
            end
            run_seq(rr, ff, 1'b0, $sformatf("rnd%0d", r), evt, to);
            if ($urandom_range(0, 3) == 0)
                run_bad(4'd0, 12'($urandom_range(0, 4095)), $sformatf("rnd%0d bad", r));
        end

        // Back to IDLE with a known configuration.
        lon = 0; gat = -100; glen = 0;
        run_seq(4'd3, 12'd33, 1'b0, "idle_again", evt, to);

`ifdef SOC_CTRL_PLL_SEQ_LOCK_MON_EN
        // Lock drops for 3 cycles in IDLE: the sequence reruns with the
        // same dividers and lock_lost_o set.
        for (int c = 0; c < 4; c++) begin
            @(posedge ref_clk_i); #1;
            pll_locked_i = (c < 3) ? 1'b0 : 1'b1;
        end
        @(posedge ref_clk_i); #1;
        lon = 0; gat = -100; glen = 0;
        check_seq(1'b1, cur_ref, cur_fb, 1'b1, "lock_mon", evt, to);
        check_int("lock_mon done_cycle", evt, 31);
`else
        // Lock drops for 3 cycles in IDLE: ignored.
        for (int c = 0; c < 6; c++) begin
            @(posedge ref_clk_i); #1;
            pll_locked_i = (c < 3) ? 1'b0 : 1'b1;
            @(negedge ref_clk_i);
            check($sformatf("lock_drop_ignored c=%0d", c), outs(),
                  {8'b1101_0000, cur_ref, cur_fb});
        end
`endif

        // Next accepted request clears lock_lost_o; done pulse is one cycle.
        lon = 10;
        run_seq(4'd6, 12'd60, 1'b0, "final", evt, to);
        check_int("final done_cycle", evt, 37);
        @(negedge ref_clk_i);
        check("idle_after_done", outs(), {8'b1101_0000, 4'd6, 12'd60});

        // Global reset mid-sequence discards the request and redoes bring-up.
        req_ref_div_i = 4'd9; req_fb_div_i = 12'd99; req_valid_i = 1'b1;
        @(posedge ref_clk_i); #1;
        req_valid_i = 1'b0;
        pll_locked_i = 1'b0;
        repeat (8) @(posedge ref_clk_i);
        #2;
        glb_arst_ni = 1'b0;
        #1;
        check("reset_mid_seq", outs(), {8'b0010_0000, 4'd1, 12'd8});
        @(posedge ref_clk_i); #1;
        glb_arst_ni = 1'b1;
        lon = 20; gat = -100; glen = 0; pre = 1'b0;
        cur_ref = 4'd1; cur_fb = 12'd8;
        check_seq(1'b0, 4'd1, 12'd8, 1'b0, "rebringup", evt, to);
        check_int("rebringup done_cycle", evt, 47);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
